// File: rtl/ram_dp_async_read.sv
// Simple dual-port RAM: synchronous write port, combinational read port, contents cleared by rst.
// Optional write-first read forwarding is enabled by defining RAM_DP_RD_BYPASS_EN.
module ram_dp_async_read #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [WIDTH-1:0]  data_wr,
  input  logic [ADDR_W-1:0] addr_rd,
  output logic [WIDTH-1:0]  data_rd
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_in_range_s;
  logic             rd_in_range_s;
  logic             wr_en_s;

  // Range checks only exist when DEPTH leaves unused address codes.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_full_range
      assign wr_in_range_s = 1'b1;
      assign rd_in_range_s = 1'b1;
    end else begin : g_part_range
      assign wr_in_range_s = ({{(32-ADDR_W){1'b0}}, addr_wr} < 32'(DEPTH));
      assign rd_in_range_s = ({{(32-ADDR_W){1'b0}}, addr_rd} < 32'(DEPTH));
    end
  endgenerate

  // An X/Z on we_n compares as unknown and therefore never enables a write.
  assign wr_en_s = (we_n == 1'b0) && wr_in_range_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_q[addr_wr] <= data_wr;
    end
  end

  always_comb begin
    data_rd = '0;
    if (rd_in_range_s) begin
      data_rd = mem_q[addr_rd];
    end else begin
      data_rd = '0;
    end
`ifdef RAM_DP_RD_BYPASS_EN
    // Forward the pending write so a same-address reader sees it before the edge.
    if (wr_en_s && !rst && rd_in_range_s && (addr_rd == addr_wr)) begin
      data_rd = data_wr;
    end else begin
      data_rd = data_rd;
    end
`endif
  end

endmodule

// File: tb/tb_ram_dp_async_read.sv
// Self-checking bench for ram_dp_async_read: directed steps with a queue scoreboard.
`timescale 1ns/1ps
module tb_ram_dp_async_read;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              we_n;
  logic [ADDR_W-1:0] addr_wr;
  logic [WIDTH-1:0]  data_wr;
  logic [ADDR_W-1:0] addr_rd;
  logic [WIDTH-1:0]  data_rd;

  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  ram_dp_async_read #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .we_n    (we_n),
    .addr_wr (addr_wr),
    .data_wr (data_wr),
    .addr_rd (addr_rd),
    .data_rd (data_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic [WIDTH-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: observed %h, scoreboard empty", tag, data_rd);
    end else begin
      exp = exp_q.pop_front();
      assert (data_rd === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h (addr_rd=%0d)", tag, data_rd, exp, addr_rd);
      end
    end
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    addr_wr = a;
    data_wr = d;
    we_n    = 1'b0;
    @(posedge clk);
    #1;
    we_n     = 1'b1;
    model[a] = d;
  endtask

  task automatic expect_addr(input logic [ADDR_W-1:0] a);
    addr_rd = a;
    exp_q.push_back(model[a]);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  d;

    rst = 1'b1; we_n = 1'b1; addr_wr = '0; data_wr = '0; addr_rd = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

    // Reset sweep
    for (int i = 0; i < DEPTH; i++) begin
      expect_addr(ADDR_W'(i));
      #1;
      check("reset_clear");
    end

    // Sequential write then read 0.1us later
    for (int i = 0; i < DEPTH; i++) begin
      d = WIDTH'($urandom);
      write_word(ADDR_W'(i), d);
      expect_addr(ADDR_W'(i));
      #100;
      check("seq_wr_rd");
    end

    // Patterned writes to random addresses, then full read-back
    for (int i = 0; i < 16; i++) begin
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      d = {a, (a[0] ? 4'hA : 4'h5)};
      write_word(a, d);
    end
    for (int i = 0; i < DEPTH; i++) begin
      expect_addr(ADDR_W'(i));
      #1;
      check("pattern_rd");
    end

    // Write disabled must hold
    write_word(4'd5, 8'hC3);
    addr_wr = 4'd5; data_wr = 8'hFF; we_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      addr_rd = 4'd5;
      exp_q.push_back(8'hC3);
      #1;
      check("hold_we_n");
    end

    // Same-address collision
    write_word(4'd7, 8'h11);
    addr_rd = 4'd7; addr_wr = 4'd7; data_wr = 8'h5A; we_n = 1'b0;
`ifdef RAM_DP_RD_BYPASS_EN
    exp_q.push_back(8'h5A);
`else
    exp_q.push_back(8'h11);
`endif
    #3;
    check("collision_pre_edge");
    @(posedge clk);
    #1;
    we_n = 1'b1;
    model[7] = 8'h5A;
    exp_q.push_back(8'h5A);
    check("collision_post_edge");
    expect_addr(4'd5);
    #1;
    check("async_addr_change");

    // Reset wins over a write on the same edge
    rst = 1'b1; we_n = 1'b0; addr_wr = 4'd2; data_wr = 8'hAA;
    @(posedge clk);
    #1;
    rst = 1'b0; we_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    expect_addr(4'd2);
    #1;
    check("rst_over_write");
    expect_addr(4'd7);
    #1;
    check("rst_clears_other");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dp_async_read.md
Name: ram_dp_async_read

Overview:
- Simple dual-port RAM: one synchronous write port and one independent asynchronous (combinational) read port.
- Used as a small register-file/buffer store in the datapath.
- Single clock domain. Memory contents are cleared by a synchronous active-high reset.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of words; any value ≥2 is legal.
- ADDR_W (localparam), $clog2(DEPTH), address width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- we_n  input  1  write enable, active-low.
- addr_wr  input  ADDR_W  write address.
- data_wr  input  WIDTH  write data.
- addr_rd  input  ADDR_W  read address.
- data_rd  output  WIDTH  read data, combinational from addr_rd.

Behaviour:
- Storage: DEPTH words of WIDTH bits. No other state.
- Reset:
  - At a rising clk edge with rst=1, every word is set to 0.
  - rst has priority over a write in the same cycle; the write is discarded.
  - Afterwards data_rd = 0 for every address.
- Write:
  - At a rising clk edge with rst=0 and we_n=0, mem[addr_wr] <= data_wr.
  - With we_n=1, memory holds.
  - Write latency is one edge; only the addressed word changes.
- Read:
  - data_rd = mem[addr_rd] continuously, with no clock involvement and zero-cycle latency.
  - A change on addr_rd is reflected in data_rd within the same delta/combinational settle.
  - The read port ignores we_n and rst, except through memory contents.
- Read-during-write, same address (default build):
  - Before the edge, data_rd shows the old word.
  - Immediately after the edge, data_rd shows the new word (read-old-before-edge).
- Out-of-range addresses (only possible when DEPTH is not a power of two):
  - A write to addr_wr ≥ DEPTH is ignored.
  - A read from addr_rd ≥ DEPTH returns 0.
- X-handling: the write port does not write on X/Z we_n. The block makes no guarantee about contents before the first reset.
- Back-to-back writes on consecutive edges are allowed with no gap cycles.

Optional Feature:
- Macro: RAM_DP_RD_BYPASS_EN.
- When defined:
  - If we_n=0, rst=0 and addr_rd==addr_wr (in range), data_rd = data_wr combinationally. This is write-first forwarding: the pending write data is visible before the edge.
  - In all other cases data_rd = mem[addr_rd].
- When not defined: pure memory read, as in Behaviour. No extra logic.

Test Plan:
- Reset: assert rst for 1 edge, then sweep addr_rd 0..15 -> data_rd == 8'h00 at every address.
- Sequential write/read:
  - For i=0..15, write random data D[i] with we_n=0 for one edge.
  - Set addr_rd=i and sample 0.1us later -> data_rd == D[i]. Expect 16/16 success, 0 errors.
- Patterned random-address write: for 16 random addresses a, write (a<<4)|(a odd ? 4'hA : 4'h5).
  - Example: a=3 -> 8'h3A, a=4 -> 8'h45.
  - Read back -> exact match every time; last write to a repeated address wins.
- Hold/disable: write 8'hC3 to addr 5, then hold we_n=1 with data_wr=8'hFF, addr_wr=5 for 4 edges -> data_rd at addr 5 stays 8'hC3.
- Async read/same-address collision:
  - Set addr_rd=7 while writing 8'h5A to addr 7 (old value 8'h11).
  - Just before the edge -> 8'h11 (8'h5A if RAM_DP_RD_BYPASS_EN). After the edge -> 8'h5A.
  - Change addr_rd to 5 with no clock edge -> data_rd updates immediately.
- Reset vs write priority: rst=1 and we_n=0 writing 8'hAA to addr 2 on the same edge -> addr 2 reads 8'h00.
